// File: rtl/calc_key_controller.sv
// Calculator key sequencer: assembles signed decimal operands from key events,
// launches ALU operations, chains results and holds the value shown on the display.
module calc_key_controller #(
    parameter int DATA_W     = 18,
    parameter int MAX_DIGITS = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        key_input,
    input  logic              valid,
    output logic              alu_start,
    output logic [1:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_err,
    output logic [DATA_W-1:0] disp_val,
    output logic              busy,
    output logic              err,
    output logic              key_drop
);

    // state    | meaning
    // ENTER_A  | building left operand
    // OP_WAIT  | operator latched, waiting for first digit of right operand
    // ENTER_B  | building right operand
    // EXEC     | ALU operation outstanding
    // RESULT   | result displayed, may be chained or negated
    // ERROR    | ALU reported an error, only AC accepted
    typedef enum logic [2:0] {
        ENTER_A, OP_WAIT, ENTER_B, EXEC, RESULT, ERROR
    } state_t;

    localparam int CW = $clog2(MAX_DIGITS + 1);

    localparam logic [4:0] KEY_AC  = 5'd10;
    localparam logic [4:0] KEY_CE  = 5'd11;
    localparam logic [4:0] KEY_NEG = 5'd12;
    localparam logic [4:0] KEY_EQ  = 5'd17;

    state_t            state;
    logic [DATA_W-1:0] mag;
    logic              neg;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;
    logic [1:0]        op;
    logic [1:0]        op_pend;
    logic              chain;

    logic              is_digit;
    logic              is_op;
    logic              is_ac;
    logic [1:0]        key_op;
    logic [DATA_W-1:0] digit_ext;
    logic [DATA_W-1:0] mag_app;
    logic [DATA_W-1:0] entry_cur;
    logic [DATA_W-1:0] entry_app;
    logic [DATA_W-1:0] entry_tog;
    logic [DATA_W-1:0] digit_pend;
    logic              digit_room;
    logic              digit_counts;

    assign is_digit  = (key_input <= 5'd9);
    assign is_op     = (key_input >= 5'd13) && (key_input <= 5'd16);
    assign is_ac     = valid && (key_input == KEY_AC);
    // DIV(13)..ADD(16) map onto op codes 11..00
    assign key_op    = 2'(5'd16 - key_input);
    assign digit_ext = {{(DATA_W-4){1'b0}}, key_input[3:0]};

    // Entry is kept as magnitude plus sign so NEG before any digit still sticks.
    assign mag_app      = (mag << 3) + (mag << 1) + digit_ext;
    assign entry_cur    = neg ? -mag : mag;
    assign entry_app    = neg ? -mag_app : mag_app;
    assign entry_tog    = neg ? mag : -mag;
    assign digit_pend   = neg ? -digit_ext : digit_ext;
    assign digit_room   = (count < CW'(MAX_DIGITS));
    assign digit_counts = (mag != '0) || (key_input[3:0] != 4'd0);

    assign alu_a  = opnd_a;
    assign alu_b  = opnd_b;
    assign alu_op = op;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ENTER_A;
            mag       <= '0;
            neg       <= 1'b0;
            count     <= '0;
            opnd_a    <= '0;
            opnd_b    <= '0;
            op        <= 2'b00;
            op_pend   <= 2'b00;
            chain     <= 1'b0;
            alu_start <= 1'b0;
            disp_val  <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
            key_drop  <= 1'b0;
        end else if (is_ac) begin
            state     <= ENTER_A;
            mag       <= '0;
            neg       <= 1'b0;
            count     <= '0;
            opnd_a    <= '0;
            opnd_b    <= '0;
            op        <= 2'b00;
            op_pend   <= 2'b00;
            chain     <= 1'b0;
            alu_start <= 1'b0;
            disp_val  <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
            key_drop  <= 1'b0;
        end else begin
            alu_start <= 1'b0;
            key_drop  <= 1'b0;
            case (state)
                ENTER_A, ENTER_B: begin
                    if (valid) begin
                        if (is_digit) begin
                            if (digit_room) begin
                                mag      <= mag_app;
                                disp_val <= entry_app;
                                if (digit_counts) count <= count + 1'b1;
                            end
                        end else if (key_input == KEY_NEG) begin
                            neg      <= ~neg;
                            disp_val <= entry_tog;
                        end else if (key_input == KEY_CE) begin
                            mag      <= '0;
                            neg      <= 1'b0;
                            count    <= '0;
                            disp_val <= '0;
                        end else if (is_op && state == ENTER_A) begin
                            opnd_a <= entry_cur;
                            op     <= key_op;
                            mag    <= '0;
                            neg    <= 1'b0;
                            count  <= '0;
                            state  <= OP_WAIT;
                        end else if ((is_op || key_input == KEY_EQ) && state == ENTER_B) begin
                            opnd_b    <= entry_cur;
                            op_pend   <= key_op;
                            chain     <= is_op;
                            mag       <= '0;
                            neg       <= 1'b0;
                            count     <= '0;
                            alu_start <= 1'b1;
                            busy      <= 1'b1;
                            state     <= EXEC;
                        end
                    end
                end
                OP_WAIT: begin
                    if (valid) begin
                        if (is_digit) begin
                            mag      <= digit_ext;
                            count    <= CW'(key_input[3:0] != 4'd0);
                            disp_val <= digit_pend;
                            state    <= ENTER_B;
                        end else if (key_input == KEY_NEG) begin
                            neg <= ~neg;
                        end else if (is_op) begin
                            op <= key_op;
                        end
                    end
                end
                EXEC: begin
                    if (valid) key_drop <= 1'b1;
                    if (alu_done) begin
                        busy <= 1'b0;
                        if (alu_err) begin
                            err   <= 1'b1;
                            state <= ERROR;
                        end else if (chain) begin
                            opnd_a   <= alu_result;
                            op       <= op_pend;
                            disp_val <= alu_result;
                            state    <= OP_WAIT;
                        end else begin
                            disp_val <= alu_result;
                            state    <= RESULT;
                        end
                    end
                end
                RESULT: begin
                    if (valid) begin
                        if (is_digit) begin
                            opnd_a   <= '0;
                            opnd_b   <= '0;
                            op       <= 2'b00;
                            mag      <= digit_ext;
                            neg      <= 1'b0;
                            count    <= CW'(key_input[3:0] != 4'd0);
                            disp_val <= digit_ext;
                            state    <= ENTER_A;
                        end else if (key_input == KEY_NEG) begin
                            disp_val <= -disp_val;
                        end else if (is_op) begin
                            opnd_a <= disp_val;
                            op     <= key_op;
                            state  <= OP_WAIT;
                        end
                    end
                end
                ERROR: begin
                    if (valid) key_drop <= 1'b1;
                end
                default: state <= ENTER_A;
            endcase
        end
    end

endmodule
